// File: rtl/csa_acc_pkg.sv
// Shared types and default sizing for the carry-save accumulator.
// The state enum is used by the controller; the constants size the datapath.
package csa_acc_pkg;

    localparam int BITS_DEF  = 40;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/csa_3to2.sv
// Combinational BITS-wide 3:2 compressor: a+b+c == sum+carry (mod 2^BITS).
// The carry vector comes out already shifted left by one; the MSB carry is dropped.
module csa_3to2 #(
    parameter int BITS = 40
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] c,
    output logic [BITS-1:0] sum,
    output logic [BITS-1:0] carry
);

    logic [BITS-1:0] maj_s;

    // Bitwise sum and majority of the three operands.
    always_comb begin
        sum   = a ^ b ^ c;
        maj_s = (a & b) | (a & c) | (b & c);
        carry = {maj_s[BITS-2:0], 1'b0};
    end

endmodule

// File: rtl/csa_accumulator.sv
// Job-based accumulator that keeps its running total in carry-save form.
// The redundant pair out_a/out_b feeds an external carry-propagate adder.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_a,
    output logic [BITS-1:0]  out_b,
    output logic             busy
);

    state_e           state_r;
    state_e           state_n;
    logic [BITS-1:0]  sum_r;
    logic [BITS-1:0]  sum_n;
    logic [BITS-1:0]  carry_r;
    logic [BITS-1:0]  carry_n;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_n;
    logic [BITS-1:0]  csa_sum_s;
    logic [BITS-1:0]  csa_carry_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    csa_3to2 #(
        .BITS (BITS)
    ) u_csa (
        .a     (sum_r),
        .b     (carry_r),
        .c     (in_data),
        .sum   (csa_sum_s),
        .carry (csa_carry_s)
    );

    // Next-state and datapath update; clear overrides everything else.
    always_comb begin
        state_n = state_r;
        sum_n   = sum_r;
        carry_n = carry_r;
        count_n = count_r;
        if (clear) begin
            state_n = ST_IDLE;
            sum_n   = {BITS{1'b0}};
            carry_n = {BITS{1'b0}};
            count_n = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sum_n   = {BITS{1'b0}};
                        carry_n = {BITS{1'b0}};
                        if (len != {CNT_W{1'b0}}) begin
                            count_n = len;
                            state_n = ST_ACC;
                        end else begin
                            count_n = {CNT_W{1'b0}};
                            state_n = ST_HOLD;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        sum_n   = csa_sum_s;
                        carry_n = csa_carry_s;
                        count_n = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (count_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_n = ST_HOLD;
                        end else begin
                            state_n = ST_ACC;
                        end
                    end else begin
                        state_n = ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    sum_n   = {BITS{1'b0}};
                    carry_n = {BITS{1'b0}};
                    count_n = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and flag registers; flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sum_r       <= {BITS{1'b0}};
            carry_r     <= {BITS{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            sum_r       <= sum_n;
            carry_r     <= carry_n;
            count_r     <= count_n;
            in_ready_r  <= (state_n == ST_ACC);
            out_valid_r <= (state_n == ST_HOLD);
            busy_r      <= (state_n != ST_IDLE);
        end
    end

    assign out_a     = sum_r;
    assign out_b     = carry_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench: directed job scenarios plus randomized traffic,
// compared every cycle against a plain-arithmetic job model.
module tb_csa_accumulator;

    localparam int BITS  = 40;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BITS-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BITS-1:0]  out_a;
    logic [BITS-1:0]  out_b;
    logic             busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: 0 = idle, 1 = taking terms, 2 = result presented
    int              m_mode;
    int              m_left;
    logic [BITS-1:0] m_total;
    bit              prev_hold = 1'b0;
    logic [BITS-1:0] prev_a;
    logic [BITS-1:0] prev_b;

    csa_accumulator #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BITS-1:0] result();
        return out_a + out_b;
    endfunction

    // Job-level model: running total with ordinary modular addition.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_left  <= 0;
            m_total <= '0;
        end else if (clear) begin
            m_mode  <= 0;
            m_left  <= 0;
            m_total <= '0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_total <= '0;
                m_left  <= int'(len);
                m_mode  <= (len != '0) ? 1 : 2;
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_total <= m_total + in_data;
                m_left  <= m_left - 1;
                if (m_left == 1) m_mode <= 2;
            end
        end else begin
            if (out_ready) m_mode <= 0;
        end
    end

    // Every-cycle comparison of the handshake flags and presented result.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {63'd0, in_ready}, {63'd0, (m_mode == 1)});
            check("out_valid", {63'd0, out_valid}, {63'd0, (m_mode == 2)});
            check("busy", {63'd0, busy}, {63'd0, (m_mode != 0)});
            if (m_mode == 2) begin
                check("result", {24'd0, result()}, {24'd0, m_total});
                if (prev_hold) begin
                    check("hold_a_stable", {24'd0, out_a}, {24'd0, prev_a});
                    check("hold_b_stable", {24'd0, out_b}, {24'd0, prev_b});
                end
            end
            prev_hold = (m_mode == 2);
            prev_a    = out_a;
            prev_b    = out_b;
        end
    end

    task automatic start_job(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one term and keep it until the block is ready to take it.
    task automatic send_term(input logic [BITS-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0]     r64;
        logic [BITS-1:0] held_a;
        logic [BITS-1:0] held_b;

        repeat (3) @(negedge clk);
        check("rst_out_a", {24'd0, out_a}, 64'd0);
        check("rst_out_b", {24'd0, out_b}, 64'd0);
        check("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Three small terms; result one cycle after the last beat
        start_job(3);
        send_term(40'd5);
        send_term(40'd7);
        send_term(40'd9);
        @(negedge clk);
        in_valid = 1'b0;
        check("sum3_valid", {63'd0, out_valid}, 64'd1);
        check("sum3_value", {24'd0, result()}, 64'd21);
        drain();

        // Wrap-around through 2^40
        start_job(2);
        send_term(40'hFF_FFFF_FFFF);
        send_term(40'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("wrap_value", {24'd0, result()}, 64'd0);

        // Result held with out_ready low while start is pulsed
        held_a = out_a;
        held_b = out_b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            len   = 8'd2;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_ready", {63'd0, in_ready}, 64'd0);
            check("hold_a", {24'd0, out_a}, {24'd0, held_a});
            check("hold_b", {24'd0, out_b}, {24'd0, held_b});
        end
        start = 1'b0;
        drain();

        // Empty job
        start_job(0);
        check("empty_valid", {63'd0, out_valid}, 64'd1);
        check("empty_ab", {out_a[31:0], out_b[31:0]}, 64'd0);
        check("empty_ready", {63'd0, in_ready}, 64'd0);
        drain();

        // Reset in the middle of a job
        start_job(4);
        send_term(40'd11);
        send_term(40'd12);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_a", {24'd0, out_a}, 64'd0);
        check("midrst_b", {24'd0, out_b}, 64'd0);
        check("midrst_flags", {61'd0, in_ready, out_valid, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_job(2);
        send_term(40'd3);
        send_term(40'd4);
        @(negedge clk);
        in_valid = 1'b0;
        check("after_rst_value", {24'd0, result()}, 64'd7);
        drain();

        // Clear after one beat; the beat offered alongside clear is dropped
        start_job(3);
        send_term(40'd50);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 40'd99;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", {63'd0, busy}, 64'd0);
        check("clear_ab", {out_a[31:0], out_b[31:0]}, 64'd0);
        start_job(1);
        send_term(40'd6);
        @(negedge clk);
        in_valid = 1'b0;
        check("after_clear_value", {24'd0, result()}, 64'd6);
        drain();

        // Start together with clear stays idle
        @(negedge clk);
        start = 1'b1;
        len   = 8'd3;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        check("start_clear_busy", {63'd0, busy}, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r64       = {$urandom(), $urandom()};
            start     = ($urandom_range(0, 9) < 3);
            len       = CNT_W'($urandom_range(0, 6));
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = ($urandom_range(0, 3) == 0) ? 40'hFF_FFFF_FFFF : r64[BITS-1:0];
            out_ready = ($urandom_range(0, 1) == 1);
            clear     = ($urandom_range(0, 99) < 2);
        end
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
